// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the byte producer / UART transmitter and uart_tx_fifo.
// Latency: n/a (wires only).
// Backpressure: FULL/OVERFLOW toward the producer; TX_Busy paces the transmit side.
//
// slave  : the FIFO block itself (takes WR_*, TX_Busy; drives status and TX_*).
// master : the surrounding logic (producer plus transmitter) or a testbench.
interface uart_tx_fifo_if #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_BIT   = 8
);
  // producer side
  logic                  WR_EN;
  logic [DATA_BIT-1:0]   WR_DATA;
  logic                  FULL;
  logic                  EMPTY;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  OVERFLOW;
  // transmitter side
  logic [DATA_BIT-1:0]   TX_Data;
  logic                  TX_Start;
  logic                  TX_Busy;

  modport slave (
    input  WR_EN, WR_DATA, TX_Busy,
    output FULL, EMPTY, COUNT, OVERFLOW, TX_Data, TX_Start
  );

  modport master (
    output WR_EN, WR_DATA, TX_Busy,
    input  FULL, EMPTY, COUNT, OVERFLOW, TX_Data, TX_Start
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO + transmit sequencer in front of the UART transmitter.
// Latency: push at edge k -> TX_Start high after edge k+1 when idle and TX_Busy low.
// Backpressure: writes while FULL are dropped and latch OVERFLOW; sends pace on TX_Busy.
//
// Ports:
//   CLK, RST          clock; synchronous active-high reset
//   bus.WR_EN/WR_DATA push one byte per clock
//   bus.FULL/EMPTY/COUNT/OVERFLOW  occupancy status, OVERFLOW is sticky
//   bus.TX_Data/TX_Start           byte and one-cycle start pulse to transmitter
//   bus.TX_Busy                    transmitter frame in progress
// Optional: define UART_TX_FIFO_CRLF_EN to send 0x0D ahead of every 0x0A byte.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int DATA_BIT    = 8,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_fifo_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int TW    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

`ifdef UART_TX_FIFO_CRLF_EN
  localparam logic [DATA_BIT-1:0] CR_BYTE = DATA_BIT'(8'h0D);
  localparam logic [DATA_BIT-1:0] LF_BYTE = DATA_BIT'(8'h0A);
`endif

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_t;

  // storage
  logic [DATA_BIT-1:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q,  count_d;
  logic                  ovf_q,    ovf_d;

  // sequencer
  state_t                state_q,    state_d;
  logic [TW-1:0]         timer_q,    timer_d;
  logic                  tx_start_q, tx_start_d;
  logic [DATA_BIT-1:0]   tx_data_q,  tx_data_d;
`ifdef UART_TX_FIFO_CRLF_EN
  logic                  cr_sent_q,  cr_sent_d;
  logic                  insert_cr;
`endif

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic [DATA_BIT-1:0]   head;

  // ---------------------------------------------------------------------------
  // Datapath decode
  // ---------------------------------------------------------------------------
  always_comb begin
    full  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    empty = (count_q == '0);
    head  = mem_q[rd_ptr_q];
    // A write while FULL is dropped even when a pop lands in the same cycle:
    // the decision is taken on the pre-edge occupancy only.
    push  = bus.WR_EN && !full;
    // Status is all registered, so a byte pushed this cycle is only visible
    // to the sequencer on the next one.
    issue = (state_q == ST_IDLE) && !empty && !bus.TX_Busy;
`ifdef UART_TX_FIFO_CRLF_EN
    // First visit to a 0x0A head sends CR and leaves the LF in place.
    insert_cr = issue && (head == LF_BYTE) && !cr_sent_q;
    pop       = issue && !insert_cr;
`else
    pop       = issue;
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (bus.WR_EN && full);

    state_d    = state_q;
    timer_d    = timer_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;

    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          tx_start_d = 1'b1;
`ifdef UART_TX_FIFO_CRLF_EN
          tx_data_d  = insert_cr ? CR_BYTE : head;
`else
          tx_data_d  = head;
`endif
          timer_d    = '0;
          state_d    = ST_WAIT_ACK;
        end
      end

      ST_WAIT_ACK: begin
        if (bus.TX_Busy) begin
          timer_d = '0;
          state_d = ST_WAIT_DONE;
        end else if (timer_q == TW'(ACK_TIMEOUT - 1)) begin
          // Transmitter never acknowledged; treat the byte as sent so a
          // missing busy flag cannot wedge the queue.
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_WAIT_DONE: begin
        if (!bus.TX_Busy) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        timer_d = '0;
        state_d = ST_IDLE;
      end
    endcase

`ifdef UART_TX_FIFO_CRLF_EN
    cr_sent_d = cr_sent_q;
    if (insert_cr) begin
      cr_sent_d = 1'b1;
    end else if (pop) begin
      cr_sent_d = 1'b0;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_q  <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
`ifdef UART_TX_FIFO_CRLF_EN
      cr_sent_q  <= cr_sent_d;
`endif
    end
  end

  // Buffer contents need no reset: occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.WR_DATA;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.FULL     = full;
  assign bus.EMPTY    = empty;
  assign bus.COUNT    = count_q;
  assign bus.OVERFLOW = ovf_q;
  assign bus.TX_Data  = tx_data_q;
  assign bus.TX_Start = tx_start_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: scenario tasks plus randomized bursts
// against a queue model of the transmitted byte stream.
// Transmitter model raises TX_Busy ack_delay clocks after a start, for busy_len clocks.
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2  = 4;
  localparam int DATA_BIT    = 8;
  localparam int ACK_TIMEOUT = 4;
  localparam int DEPTH       = 1 << DEPTH_LOG2;

  logic CLK;
  logic RST;

  uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_BIT(DATA_BIT)) bus ();

  uart_tx_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_BIT   (DATA_BIT),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  // transmitter model controls
  logic model_busy;
  logic busy_force;
  logic xmit_en;
  int   busy_len;
  int   ack_delay;

  assign bus.TX_Busy = model_busy | busy_force;

  // observed starts and expected stream
  logic [7:0] tx_log[$];
  int         start_cyc[$];
  logic [7:0] exp_q[$];

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.TX_Start === 1'b1) begin
      tx_log.push_back(bus.TX_Data);
      start_cyc.push_back(cyc);
    end
  end

  initial begin
    model_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (xmit_en && bus.TX_Start === 1'b1) begin
        repeat (ack_delay) @(negedge CLK);
        model_busy = 1'b1;
        repeat (busy_len) @(negedge CLK);
        model_busy = 1'b0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    bus.WR_EN   = 1'b1;
    bus.WR_DATA = b;
    @(posedge CLK);
    #1;
    bus.WR_EN   = 1'b0;
  endtask

  // Expected on-line stream for one stored byte.
  task automatic expect_byte(input logic [7:0] b);
`ifdef UART_TX_FIFO_CRLF_EN
    if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(b);
  endtask

  task automatic clear_logs;
    tx_log.delete();
    start_cyc.delete();
    exp_q.delete();
  endtask

  task automatic do_reset;
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
    total_cnt++; if (bus.COUNT !== 5'd0) $display("FAIL reset_count: got %0d want 0", bus.COUNT); else pass_cnt++;
    total_cnt++; if (bus.EMPTY !== 1'b1) $display("FAIL reset_empty: got %b want 1", bus.EMPTY); else pass_cnt++;
    total_cnt++; if (bus.FULL !== 1'b0) $display("FAIL reset_full: got %b want 0", bus.FULL); else pass_cnt++;
    total_cnt++; if (bus.OVERFLOW !== 1'b0) $display("FAIL reset_overflow: got %b want 0", bus.OVERFLOW); else pass_cnt++;
    total_cnt++; if (bus.TX_Start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", bus.TX_Start); else pass_cnt++;
    total_cnt++; if (bus.TX_Data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", bus.TX_Data); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_byte;
    int pk;
    xmit_en = 1'b1; busy_len = 5; ack_delay = 1;
    clear_logs();
    push(8'hD3);
    pk = cyc;
    total_cnt++; if (bus.COUNT !== 5'd1) $display("FAIL single_count_after_push: got %0d want 1", bus.COUNT); else pass_cnt++;
    total_cnt++; if (bus.EMPTY !== 1'b0) $display("FAIL single_empty_after_push: got %b want 0", bus.EMPTY); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.TX_Start !== 1'b1) $display("FAIL single_start: got %b want 1", bus.TX_Start); else pass_cnt++;
    total_cnt++; if (bus.TX_Data !== 8'hD3) $display("FAIL single_data: got %h want d3", bus.TX_Data); else pass_cnt++;
    total_cnt++; if (bus.EMPTY !== 1'b1) $display("FAIL single_empty_after_pop: got %b want 1", bus.EMPTY); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.TX_Start !== 1'b0) $display("FAIL single_start_width: got %b want 0", bus.TX_Start); else pass_cnt++;
    tick(20);
    total_cnt++; if (tx_log.size() !== 1) $display("FAIL single_start_count: got %0d want 1", tx_log.size()); else pass_cnt++;
    if (start_cyc.size() > 0) begin
      total_cnt++; if (start_cyc[0] !== pk + 1) $display("FAIL single_latency: start cycle %0d want %0d", start_cyc[0], pk + 1); else pass_cnt++;
    end
    total_cnt++; if (bus.TX_Data !== 8'hD3) $display("FAIL single_data_hold: got %h want d3", bus.TX_Data); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  // The transmitter is held busy during the burst so all 16 bytes stay queued.
  task automatic test_burst;
    xmit_en = 1'b1; busy_len = 20; ack_delay = 1;
    clear_logs();
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(8'h41 + 8'(i));
      expect_byte(8'h41 + 8'(i));
    end
    total_cnt++; if (bus.FULL !== 1'b1) $display("FAIL burst_full: got %b want 1", bus.FULL); else pass_cnt++;
    total_cnt++; if (bus.COUNT !== 5'(DEPTH)) $display("FAIL burst_count: got %0d want %0d", bus.COUNT, DEPTH); else pass_cnt++;
    busy_force = 1'b0;
    tick(16 * (busy_len + ack_delay + 3) + 20);
    total_cnt++; if (tx_log.size() !== exp_q.size()) $display("FAIL burst_len: got %0d want %0d", tx_log.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
      total_cnt++; if (tx_log[i] !== exp_q[i]) $display("FAIL burst_byte[%0d]: got %h want %h", i, tx_log[i], exp_q[i]); else pass_cnt++;
    end
    for (int i = 1; i < start_cyc.size(); i++) begin
      total_cnt++;
      if (start_cyc[i] - start_cyc[i-1] < busy_len + ack_delay + 2)
        $display("FAIL burst_spacing[%0d]: got %0d want >= %0d", i, start_cyc[i] - start_cyc[i-1], busy_len + ack_delay + 2);
      else pass_cnt++;
    end
    total_cnt++; if (bus.OVERFLOW !== 1'b0) $display("FAIL burst_overflow: got %b want 0", bus.OVERFLOW); else pass_cnt++;
    total_cnt++; if (bus.EMPTY !== 1'b1) $display("FAIL burst_empty: got %b want 1", bus.EMPTY); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  // The dropped 0xFF write coincides with the first pop out of the full FIFO.
  task automatic test_overflow;
    do_reset();
    xmit_en = 1'b1; busy_len = 2; ack_delay = 0;
    clear_logs();
    busy_force = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(8'h60 + 8'(i));
      expect_byte(8'h60 + 8'(i));
    end
    total_cnt++; if (bus.OVERFLOW !== 1'b0) $display("FAIL ovf_before: got %b want 0", bus.OVERFLOW); else pass_cnt++;
    busy_force = 1'b0;
    push(8'hFF);
    total_cnt++; if (bus.OVERFLOW !== 1'b1) $display("FAIL ovf_set: got %b want 1", bus.OVERFLOW); else pass_cnt++;
    total_cnt++; if (bus.COUNT !== 5'(DEPTH - 1)) $display("FAIL ovf_count: got %0d want %0d", bus.COUNT, DEPTH - 1); else pass_cnt++;
    tick(16 * (busy_len + ack_delay + 3) + 20);
    total_cnt++; if (bus.OVERFLOW !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", bus.OVERFLOW); else pass_cnt++;
    total_cnt++; if (tx_log.size() !== exp_q.size()) $display("FAIL ovf_len: got %0d want %0d", tx_log.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
      total_cnt++; if (tx_log[i] !== exp_q[i]) $display("FAIL ovf_byte[%0d]: got %h want %h", i, tx_log[i], exp_q[i]); else pass_cnt++;
    end
    do_reset();
    total_cnt++; if (bus.OVERFLOW !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", bus.OVERFLOW); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ack_timeout;
    int pk;
    xmit_en = 1'b0;
    clear_logs();
    push(8'h55);
    pk = cyc;
    push(8'h56);
    tick(20);
    total_cnt++; if (tx_log.size() !== 2) $display("FAIL timeout_len: got %0d want 2", tx_log.size()); else pass_cnt++;
    if (tx_log.size() == 2) begin
      total_cnt++; if (tx_log[0] !== 8'h55) $display("FAIL timeout_byte0: got %h want 55", tx_log[0]); else pass_cnt++;
      total_cnt++; if (tx_log[1] !== 8'h56) $display("FAIL timeout_byte1: got %h want 56", tx_log[1]); else pass_cnt++;
      total_cnt++; if (start_cyc[0] !== pk + 1) $display("FAIL timeout_first: start cycle %0d want %0d", start_cyc[0], pk + 1); else pass_cnt++;
      total_cnt++;
      if (start_cyc[1] - start_cyc[0] !== ACK_TIMEOUT + 1)
        $display("FAIL timeout_gap: got %0d want %0d", start_cyc[1] - start_cyc[0], ACK_TIMEOUT + 1);
      else pass_cnt++;
    end
    total_cnt++; if (bus.EMPTY !== 1'b1) $display("FAIL timeout_empty: got %b want 1", bus.EMPTY); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_burst;
    xmit_en = 1'b1; busy_len = 20; ack_delay = 1;
    clear_logs();
    for (int i = 0; i < 6; i++) push(8'h70 + 8'(i));
    total_cnt++; if (bus.COUNT !== 5'd5) $display("FAIL midrst_queued: got %0d want 5", bus.COUNT); else pass_cnt++;
    do_reset();
    total_cnt++; if (bus.COUNT !== 5'd0) $display("FAIL midrst_count: got %0d want 0", bus.COUNT); else pass_cnt++;
    total_cnt++; if (bus.TX_Start !== 1'b0) $display("FAIL midrst_start: got %b want 0", bus.TX_Start); else pass_cnt++;
    total_cnt++; if (bus.TX_Data !== 8'h00) $display("FAIL midrst_data: got %h want 00", bus.TX_Data); else pass_cnt++;
    tick(60);
    total_cnt++; if (tx_log.size() !== 1) $display("FAIL midrst_no_start: got %0d starts want 1", tx_log.size()); else pass_cnt++;
    push(8'h5A);
    tick(30);
    total_cnt++; if (tx_log.size() !== 2) $display("FAIL midrst_resume_len: got %0d want 2", tx_log.size()); else pass_cnt++;
    if (tx_log.size() == 2) begin
      total_cnt++; if (tx_log[1] !== 8'h5A) $display("FAIL midrst_resume_byte: got %h want 5a", tx_log[1]); else pass_cnt++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_crlf;
    xmit_en = 1'b1; busy_len = 3; ack_delay = 0;
    clear_logs();
    push(8'h41);
    push(8'h0A);
    exp_q.push_back(8'h41);
`ifdef UART_TX_FIFO_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
    tick(40);
    total_cnt++; if (tx_log.size() !== exp_q.size()) $display("FAIL crlf_len: got %0d want %0d", tx_log.size(), exp_q.size()); else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
      total_cnt++; if (tx_log[i] !== exp_q[i]) $display("FAIL crlf_byte[%0d]: got %h want %h", i, tx_log[i], exp_q[i]); else pass_cnt++;
    end
    total_cnt++; if (bus.EMPTY !== 1'b1) $display("FAIL crlf_empty: got %b want 1", bus.EMPTY); else pass_cnt++;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_random;
    int n;
    int gap;
    logic [7:0] b;
    xmit_en = 1'b1;
    for (int r = 0; r < 6; r++) begin
      busy_len  = $urandom_range(1, 8);
      ack_delay = $urandom_range(0, 2);
      n         = $urandom_range(1, 16);
      clear_logs();
      for (int i = 0; i < n; i++) begin
        b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
        push(b);
        expect_byte(b);
        gap = $urandom_range(0, 3);
        if (gap > 0) tick(gap);
      end
      tick(2 * n * (busy_len + ack_delay + 3) + 20);
      total_cnt++; if (tx_log.size() !== exp_q.size()) $display("FAIL rand%0d_len: got %0d want %0d", r, tx_log.size(), exp_q.size()); else pass_cnt++;
      for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++) begin
        total_cnt++; if (tx_log[i] !== exp_q[i]) $display("FAIL rand%0d_byte[%0d]: got %h want %h", r, i, tx_log[i], exp_q[i]); else pass_cnt++;
      end
      for (int i = 1; i < start_cyc.size(); i++) begin
        total_cnt++;
        if (start_cyc[i] - start_cyc[i-1] < busy_len + ack_delay + 2)
          $display("FAIL rand%0d_spacing[%0d]: got %0d want >= %0d", r, i, start_cyc[i] - start_cyc[i-1], busy_len + ack_delay + 2);
        else pass_cnt++;
      end
      total_cnt++; if (bus.EMPTY !== 1'b1) $display("FAIL rand%0d_empty: got %b want 1", r, bus.EMPTY); else pass_cnt++;
      total_cnt++; if (bus.OVERFLOW !== 1'b0) $display("FAIL rand%0d_overflow: got %b want 0", r, bus.OVERFLOW); else pass_cnt++;
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    RST         = 1'b0;
    bus.WR_EN   = 1'b0;
    bus.WR_DATA = 8'h00;
    busy_force  = 1'b0;
    xmit_en     = 1'b0;
    busy_len    = 1;
    ack_delay   = 0;
    tick(1);

    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_ack_timeout();
    test_reset_mid_burst();
    test_crlf();
    test_random();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
